// File: rtl/id_ctrl_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared definitions for the ID-stage control path. Holds the RV
//               opcode constants, the ALU-class encodings, the hazard FSM
//               state type and the packed control bundle carried into ID/EX.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  // ALU class encodings
  localparam logic [1:0] c_ALU_ADD    = 2'b00;
  localparam logic [1:0] c_ALU_BRANCH = 2'b01;
  localparam logic [1:0] c_ALU_RTYPE  = 2'b10;
  localparam logic [1:0] c_ALU_ITYPE  = 2'b11;

  // Load-use hazard FSM
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Control bundle registered into ID/EX
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jal;
    logic       jalr;
    logic       illegal;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int    c_CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t c_CTRL_NOP = '0;

  // Build a legal control word from the flag vector
  // {RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, JAL, JALR}.
  function automatic ctrl_t mk_ctrl(input logic [7:0] flags, input logic [1:0] alu);
    ctrl_t c;
    c            = c_CTRL_NOP;
    c.reg_write  = flags[7];
    c.alu_src    = flags[6];
    c.branch     = flags[5];
    c.mem_read   = flags[4];
    c.mem_write  = flags[3];
    c.mem_to_reg = flags[2];
    c.jal        = flags[1];
    c.jalr       = flags[0];
    c.alu_op     = alu;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ctrl_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ctrl_stage_if
// Description : Bundle between the IF/ID side, the ID control stage and EX.
//               master drives instruction/handshake, slave (the stage) drives
//               the stall request and the registered ID/EX control fields.
// Ports       : instr_i, instr_vld_i, stall_i, flush_i  (master -> slave)
//               stall_o, vld_o, control fields, ALU_op_o, rd_o, illegal_o
//                                                      (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ctrl_stage_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
);
  logic [31:0]        instr_i;
  logic               instr_vld_i;
  logic               stall_i;
  logic               flush_i;

  logic               stall_o;
  logic               vld_o;
  logic               RegWrite_o;
  logic               ALUSrc_o;
  logic               Branch_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               MemtoReg_o;
  logic               JALornot_o;
  logic               Jalr_o;
  logic [ALUOP_W-1:0] ALU_op_o;
  logic [REG_AW-1:0]  rd_o;
  logic               illegal_o;

  modport master (
    output instr_i, instr_vld_i, stall_i, flush_i,
    input  stall_o, vld_o, RegWrite_o, ALUSrc_o, Branch_o, MemRead_o,
           MemWrite_o, MemtoReg_o, JALornot_o, Jalr_o, ALU_op_o, rd_o,
           illegal_o
  );

  modport slave (
    input  instr_i, instr_vld_i, stall_i, flush_i,
    output stall_o, vld_o, RegWrite_o, ALUSrc_o, Branch_o, MemRead_o,
           MemWrite_o, MemtoReg_o, JALornot_o, Jalr_o, ALU_op_o, rd_o,
           illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/id_ctrl_stage_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Purely combinational opcode -> control table, plus flags that
//               say which source registers the instruction actually reads.
// Ports       : i_opcode  in  7   instr[6:0]
//               o_ctrl    out     control bundle (illegal set for unknown op)
//               o_use_rs1 out 1   instruction reads rs1
//               o_use_rs2 out 1   instruction reads rs2
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int EN_JALR = 1
) (
  input  wire [6:0] i_opcode,
  output ctrl_t     o_ctrl,
  output logic      o_use_rs1,
  output logic      o_use_rs2
);

  always_comb begin
    o_ctrl    = c_CTRL_NOP;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (i_opcode)
      c_OP_LOAD: begin
        o_ctrl    = mk_ctrl(8'b1101_0100, c_ALU_ADD);
        o_use_rs1 = 1'b1;
      end
      c_OP_STORE: begin
        o_ctrl    = mk_ctrl(8'b0100_1000, c_ALU_ADD);
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      c_OP_BRANCH: begin
        o_ctrl    = mk_ctrl(8'b0010_0000, c_ALU_BRANCH);
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      c_OP_IMM: begin
        o_ctrl    = mk_ctrl(8'b1100_0000, c_ALU_ITYPE);
        o_use_rs1 = 1'b1;
      end
      c_OP_REG: begin
        o_ctrl    = mk_ctrl(8'b1000_0000, c_ALU_RTYPE);
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      c_OP_JAL: begin
        // JAL has no register source: bits [19:15] are immediate
        o_ctrl    = mk_ctrl(8'b1010_0010, c_ALU_ADD);
      end
      c_OP_JALR: begin
        if (EN_JALR != 0) begin
          o_ctrl    = mk_ctrl(8'b1100_0011, c_ALU_ADD);
          o_use_rs1 = 1'b1;
        end else begin
          o_ctrl.illegal = 1'b1;
        end
      end
      default: begin
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ctrl_stage
// Description : ID-stage control path. Decodes the instruction, detects
//               load-use hazards against the load sitting in EX, inserts
//               LOAD_LAT bubbles per hazard and registers the control fields
//               into ID/EX. Flush beats downstream stall beats hazard.
// Ports       : clk_i  in  1   clock, rising edge
//               rst_i  in  1   asynchronous reset, active low
//               bus    slave   instruction in, stall_o + ID/EX fields out
// Revision    : 1.0 - initial release
// ============================================================================
module id_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 2,
  parameter int LOAD_LAT = 1,   // 1..7
  parameter int EN_JALR  = 1
) (
  input  wire            clk_i,
  input  wire            rst_i,
  id_ctrl_stage_if.slave bus
);

  localparam bit         c_NEED_HOLD = (LOAD_LAT > 1);
  localparam logic [2:0] c_HOLD_CNT  = 3'(LOAD_LAT - 1);

  // Decode
  ctrl_t             w_dec;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic              w_unused_instr;

  ctrl_decode #(
    .EN_JALR (EN_JALR)
  ) u_decode (
    .i_opcode  (bus.instr_i[6:0]),
    .o_ctrl    (w_dec),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_rd  = bus.instr_i[7  +: REG_AW];
  assign w_rs1 = bus.instr_i[15 +: REG_AW];
  assign w_rs2 = bus.instr_i[20 +: REG_AW];
  // funct3/funct7 and immediates are consumed further down the pipe
  assign w_unused_instr = ^bus.instr_i;

  // ID/EX register
  logic              r_vld;
  ctrl_t             r_ctrl;
  logic [REG_AW-1:0] r_rd;

  // FSM
  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;
  logic w_idex_en;

  // Load in EX writing a register this instruction reads. x0 never hazards.
  assign w_hazard = bus.instr_vld_i & r_vld & r_ctrl.mem_read &
                    (r_rd != '0) &
                    ((w_use_rs1 & (w_rs1 == r_rd)) |
                     (w_use_rs2 & (w_rs2 == r_rd)));

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.flush_i) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 3'd0;
    end else if (!bus.stall_i) begin
      case (r_state)
        ST_RUN: begin
          // Single-bubble loads need no HOLD: the bubble itself clears EX
          if (w_hazard && c_NEED_HOLD) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = c_HOLD_CNT;
          end
        end
        ST_HOLD: begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Outputs: stall request and ID/EX load control
  always_comb begin
    w_stall   = 1'b0;
    w_bubble  = 1'b0;
    w_idex_en = 1'b1;
    if (bus.flush_i) begin
      w_bubble = 1'b1;
    end else if (bus.stall_i) begin
      w_stall   = 1'b1;
      w_idex_en = 1'b0;
    end else if (r_state == ST_HOLD) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_hazard) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  // ID/EX register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld  <= 1'b0;
      r_ctrl <= c_CTRL_NOP;
      r_rd   <= '0;
    end else if (w_idex_en) begin
      if (w_bubble || !bus.instr_vld_i) begin
        r_vld  <= 1'b0;
        r_ctrl <= c_CTRL_NOP;
        r_rd   <= '0;
      end else begin
        r_vld  <= 1'b1;
        r_ctrl <= w_dec;
        r_rd   <= w_rd;
      end
    end
  end

  assign bus.stall_o    = w_stall;
  assign bus.vld_o      = r_vld;
  assign bus.RegWrite_o = r_ctrl.reg_write;
  assign bus.ALUSrc_o   = r_ctrl.alu_src;
  assign bus.Branch_o   = r_ctrl.branch;
  assign bus.MemRead_o  = r_ctrl.mem_read;
  assign bus.MemWrite_o = r_ctrl.mem_write;
  assign bus.MemtoReg_o = r_ctrl.mem_to_reg;
  assign bus.JALornot_o = r_ctrl.jal;
  assign bus.Jalr_o     = r_ctrl.jalr;
  assign bus.ALU_op_o   = ALUOP_W'(r_ctrl.alu_op);
  assign bus.rd_o       = r_rd;
  assign bus.illegal_o  = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ctrl_stage
// Description : Directed self-checking bench for id_ctrl_stage. Two instances
//               (LOAD_LAT=1 and LOAD_LAT=3) are exercised in turn; expected
//               ID/EX contents are queued when a cycle is driven and compared
//               after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ctrl_stage;

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic       alus;
    logic       br;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       jal;
    logic       jalr;
    logic       ill;
    logic [1:0] alu;
    logic [4:0] rd;
  } out_t;

  localparam out_t BUB = '0;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   fails;
  out_t sb[$];

  id_ctrl_stage_if #(.REG_AW(5), .ALUOP_W(2)) if1 ();
  id_ctrl_stage_if #(.REG_AW(5), .ALUOP_W(2)) if3 ();

  id_ctrl_stage #(.REG_AW(5), .ALUOP_W(2), .LOAD_LAT(1), .EN_JALR(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if1)
  );

  id_ctrl_stage #(.REG_AW(5), .ALUOP_W(2), .LOAD_LAT(3), .EN_JALR(1)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  // Reference control table
  function automatic out_t exp_dec(input logic [31:0] ins);
    out_t o;
    o     = '0;
    o.vld = 1'b1;
    o.rd  = ins[11:7];
    case (ins[6:0])
      7'b0000011: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b1101010000;
      7'b0100011: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b0100100000;
      7'b1100011: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b0010000001;
      7'b0010011: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b1100000011;
      7'b0110011: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b1000000010;
      7'b1101111: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b1010001000;
      7'b1100111: {o.rw, o.alus, o.br, o.mr, o.mw, o.m2r, o.jal, o.jalr, o.alu} = 10'b1100001100;
      default:    o.ill = 1'b1;
    endcase
    return o;
  endfunction

  function automatic out_t get_out(input int d);
    if (d == 1)
      return {if1.vld_o, if1.RegWrite_o, if1.ALUSrc_o, if1.Branch_o, if1.MemRead_o,
              if1.MemWrite_o, if1.MemtoReg_o, if1.JALornot_o, if1.Jalr_o,
              if1.illegal_o, if1.ALU_op_o, if1.rd_o};
    else
      return {if3.vld_o, if3.RegWrite_o, if3.ALUSrc_o, if3.Branch_o, if3.MemRead_o,
              if3.MemWrite_o, if3.MemtoReg_o, if3.JALornot_o, if3.Jalr_o,
              if3.illegal_o, if3.ALU_op_o, if3.rd_o};
  endfunction

  function automatic logic get_stall(input int d);
    return (d == 1) ? if1.stall_o : if3.stall_o;
  endfunction

  task automatic drive(input int d, input logic [31:0] ins, input logic v,
                       input logic st, input logic fl);
    if (d == 1) begin
      if1.instr_i = ins; if1.instr_vld_i = v; if1.stall_i = st; if1.flush_i = fl;
    end else begin
      if3.instr_i = ins; if3.instr_vld_i = v; if3.stall_i = st; if3.flush_i = fl;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input out_t obs, input out_t expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check stall_o before the edge, queue the
  // expected ID/EX contents and compare them after the edge.
  task automatic cycle(input int d, input logic [31:0] ins, input logic v,
                       input logic st, input logic fl, input logic exp_stall,
                       input out_t exp_next, input string tag);
    out_t want;
    drive(d, ins, v, st, fl);
    #1;
    check_bit({tag, " stall_o"}, get_stall(d), exp_stall);
    sb.push_back(exp_next);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      want = sb.pop_front();
      check_out({tag, " idex"}, get_out(d), want);
    end
    @(negedge clk);
  endtask

  logic [31:0] t1 [8];
  logic [31:0] ld5, ld0, add, addr2, sd5, opi5, a0, jal, op8, opi, opdep;

  initial begin
    checks = 0; passed = 0; fails = 0;
    rst_n  = 1'b0;
    drive(1, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(3, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    check_out("reset dut1", get_out(1), BUB);
    check_bit("reset dut1 stall_o", get_stall(1), 1'b0);
    check_out("reset dut3", get_out(3), BUB);
    check_bit("reset dut3 stall_o", get_stall(3), 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    ld5   = mk(7'b0000011, 5, 1, 0);
    ld0   = mk(7'b0000011, 0, 1, 0);
    add   = mk(7'b0110011, 6, 5, 7);
    addr2 = mk(7'b0110011, 6, 7, 5);
    sd5   = mk(7'b0100011, 0, 1, 5);
    opi5  = mk(7'b0010011, 3, 1, 5);
    a0    = mk(7'b0110011, 1, 0, 0);
    jal   = mk(7'b1101111, 1, 5, 5);
    op8   = mk(7'b0110011, 8, 1, 2);
    opi   = mk(7'b0010011, 3, 4, 0);
    opdep = mk(7'b0110011, 9, 5, 5);

    // Every opcode, no hazards
    t1 = '{mk(7'b0000011, 5, 1, 0), mk(7'b0100011, 0, 2, 3),
           mk(7'b1100011, 0, 1, 2), mk(7'b0010011, 7, 3, 0),
           mk(7'b0110011, 8, 1, 2), mk(7'b1101111, 1, 0, 0),
           mk(7'b1100111, 2, 3, 0), mk(7'b1111111, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      cycle(1, t1[i], 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(t1[i]), $sformatf("dec%0d", i));
    end
    cycle(1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, "invalid");

    // Load-use, LOAD_LAT=1: rs1, rs2 and store-data dependencies
    cycle(1, ld5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5),   "l1 ld");
    cycle(1, add,   1'b1, 1'b0, 1'b0, 1'b1, BUB,            "l1 rs1 bubble");
    cycle(1, add,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(add),   "l1 rs1 add");
    cycle(1, ld5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5),   "l1 ld b");
    cycle(1, addr2, 1'b1, 1'b0, 1'b0, 1'b1, BUB,            "l1 rs2 bubble");
    cycle(1, addr2, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(addr2), "l1 rs2 add");
    cycle(1, ld5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5),   "l1 ld c");
    cycle(1, sd5,   1'b1, 1'b0, 1'b0, 1'b1, BUB,            "l1 sd bubble");
    cycle(1, sd5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(sd5),   "l1 sd");
    cycle(1, ld5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5),   "l1 ld d");
    cycle(1, opi5,  1'b1, 1'b0, 1'b0, 1'b0, exp_dec(opi5),  "opi rs2 ignored");

    // No hazard on x0 or on JAL
    cycle(1, ld0, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld0), "ld x0");
    cycle(1, a0,  1'b1, 1'b0, 1'b0, 1'b0, exp_dec(a0),  "add x0 src");
    cycle(1, ld5, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5), "ld before jal");
    cycle(1, jal, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(jal), "jal no stall");

    // Downstream stall freezes ID/EX; flush in RUN kills the instruction
    cycle(1, op8, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(op8), "op");
    cycle(1, opi, 1'b1, 1'b1, 1'b0, 1'b1, exp_dec(op8), "freeze 1");
    cycle(1, opi, 1'b1, 1'b1, 1'b0, 1'b1, exp_dec(op8), "freeze 2");
    cycle(1, opi, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(opi), "unfreeze");
    cycle(1, op8, 1'b1, 1'b0, 1'b1, 1'b0, BUB,          "flush run");
    drive(1, 32'd0, 1'b0, 1'b0, 1'b0);

    // LOAD_LAT=3: exactly three bubbles
    cycle(3, ld5, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5), "l3 ld");
    for (int i = 0; i < 3; i++) begin
      cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b1, BUB, $sformatf("l3 bubble%0d", i));
    end
    cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(add), "l3 add");

    // Flush on the second bubble returns straight to RUN
    cycle(3, ld5,   1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5),   "fl ld");
    cycle(3, add,   1'b1, 1'b0, 1'b0, 1'b1, BUB,            "fl bubble1");
    cycle(3, add,   1'b1, 1'b0, 1'b1, 1'b0, BUB,            "fl flush");
    cycle(3, opdep, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(opdep), "fl run");

    // Asynchronous reset while in HOLD
    cycle(3, ld5, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5), "rs ld");
    cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b1, BUB,          "rs bubble1");
    drive(3, add, 1'b1, 1'b0, 1'b0);
    #1;
    check_bit("rs hold stall_o", get_stall(3), 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("rs async clear", get_out(3), BUB);
    check_bit("rs async stall_o", get_stall(3), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(add), "rs restart add");
    cycle(3, ld5, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(ld5), "rs restart ld");
    for (int i = 0; i < 3; i++) begin
      cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b1, BUB, $sformatf("rs bubble%0d", i));
    end
    cycle(3, add, 1'b1, 1'b0, 1'b0, 1'b0, exp_dec(add), "rs final add");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
